// File: rtl/wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// wb_arbiter_rr
//
// Round-robin Wishbone arbiter that shares one Wishbone slave between NM bus
// masters. A grant is held for the whole Wishbone cycle (CYC high). A watchdog
// releases the bus and pulses a per-master error if the slave never acks a
// strobe within TIMEOUT cycles (TIMEOUT = 0 disables the watchdog).
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_m_adr/i_m_dat      per-master address / write data, master i at [i*32+:32]
//   i_m_sel              per-master byte selects, master i at [i*4+:4]
//   i_m_we/cyc/stb       per-master write enable, cycle, strobe
//   o_m_dat              slave read data broadcast to every master
//   o_m_ack              per-master ack (slave ack gated by the grant)
//   o_m_err              per-master registered one-cycle watchdog error pulse
//   o_s_*                shared slave port, muxed from the granted master
//   i_s_dat, i_s_ack     slave read data and ack
//   o_grant              registered one-hot grant
// ---------------------------------------------------------------------------
module wb_arbiter_rr #(
  parameter int NM      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NM*32-1:0] i_m_adr,
  input  logic [NM*32-1:0] i_m_dat,
  input  logic [NM*4-1:0]  i_m_sel,
  input  logic [NM-1:0]    i_m_we,
  input  logic [NM-1:0]    i_m_cyc,
  input  logic [NM-1:0]    i_m_stb,
  output logic [31:0]      o_m_dat,
  output logic [NM-1:0]    o_m_ack,
  output logic [NM-1:0]    o_m_err,
  output logic [31:0]      o_s_adr,
  output logic [31:0]      o_s_dat,
  output logic [3:0]       o_s_sel,
  output logic             o_s_we,
  output logic             o_s_cyc,
  output logic             o_s_stb,
  input  logic [31:0]      i_s_dat,
  input  logic             i_s_ack,
  output logic [NM-1:0]    o_grant
);

  localparam int LW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Last watchdog count before expiry; the error fires on the cycle the count
  // sits here with the strobe still unacknowledged.
  localparam logic [WDW-1:0] WD_LAST  = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  // Reset "last" to the highest index so master 0 is searched first.
  localparam logic [LW-1:0]  LAST_RST = LW'(NM - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [LW-1:0]   last_q,  last_d;
  logic [WDW-1:0]  wdog_q,  wdog_d;
  logic [NM-1:0]   err_q,   err_d;

  logic            win_found_s;
  logic [LW-1:0]   win_idx_s;
  logic [LW-1:0]   gidx_s;
  logic            gcyc_s;
  logic            gstb_s;

  // Round-robin search: first requester after the last winner, wrapping.
  always_comb begin
    int cand;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand        = 0;
    for (int k = 1; k <= NM; k++) begin
      cand = (int'(last_q) + k) % NM;
      if (!win_found_s && i_m_cyc[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = LW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot grant to index for the slave-port mux (index 0 when no grant).
  always_comb begin
    gidx_s = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        gidx_s = LW'(i);
      end else begin
        gidx_s = gidx_s;
      end
    end
  end

  assign gcyc_s = |(i_m_cyc & grant_q);
  assign gstb_s = |(i_m_stb & grant_q);

  // Next-state logic for the arbitration FSM and the watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          grant_d            = '0;
          grant_d[win_idx_s] = 1'b1;
          last_d             = win_idx_s;
          state_d            = S_BUSY;
        end else begin
          grant_d = '0;
        end
      end
      S_BUSY: begin
        if (!gcyc_s) begin
          // Release takes priority over a coincident timeout: no error.
          state_d = S_IDLE;
          grant_d = '0;
        end else if (gstb_s && !i_s_ack) begin
          if ((TIMEOUT > 0) && (wdog_q == WD_LAST)) begin
            err_d   = grant_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else if (TIMEOUT > 0) begin
            wdog_d = wdog_q + WDW'(1);
          end else begin
            wdog_d = '0;
          end
        end else begin
          // Ack (which wins over a coincident timeout) or strobe low.
          wdog_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      wdog_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Slave port: the granted master's signals; cyc/stb/we forced low with no grant.
  assign o_s_adr = i_m_adr[int'(gidx_s)*32 +: 32];
  assign o_s_dat = i_m_dat[int'(gidx_s)*32 +: 32];
  assign o_s_sel = i_m_sel[int'(gidx_s)*4 +: 4];
  assign o_s_we  = |(i_m_we & grant_q);
  assign o_s_cyc = gcyc_s;
  assign o_s_stb = gstb_s;

  assign o_m_dat = i_s_dat;
  assign o_m_ack = {NM{i_s_ack}} & grant_q;
  assign o_m_err = err_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter_rr
//
// Random Wishbone masters and a random-latency slave drive the arbiter. A
// behavioural model (owner index, last winner, wait count) predicts each
// cycle's grant/ack/error activity and pushes it into a queue; a monitor pops
// and compares whenever the DUT shows an ack, an error or a fresh grant.
// Directed checks cover the reset state and an asynchronous reset mid-cycle.
// ---------------------------------------------------------------------------
module tb_wb_arbiter_rr;

  localparam int NM = 3;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM*32-1:0] m_adr, m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [31:0]      o_m_dat;
  logic [NM-1:0]    o_m_ack, o_m_err, o_grant;
  logic [31:0]      s_adr, s_dat_o, s_dat_i;
  logic [3:0]       s_sel;
  logic             s_we, s_cyc, s_stb, s_ack;

  wb_arbiter_rr #(.NM(NM), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_m_adr (m_adr),
    .i_m_dat (m_dat),
    .i_m_sel (m_sel),
    .i_m_we  (m_we),
    .i_m_cyc (m_cyc),
    .i_m_stb (m_stb),
    .o_m_dat (o_m_dat),
    .o_m_ack (o_m_ack),
    .o_m_err (o_m_err),
    .o_s_adr (s_adr),
    .o_s_dat (s_dat_o),
    .o_s_sel (s_sel),
    .o_s_we  (s_we),
    .o_s_cyc (s_cyc),
    .o_s_stb (s_stb),
    .i_s_dat (s_dat_i),
    .i_s_ack (s_ack),
    .o_grant (o_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NM-1:0] grant;
    logic [NM-1:0] ack;
    logic [NM-1:0] err;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [3:0]    s_sel;
    logic [31:0]   s_adr;
    logic [31:0]   s_dat;
    logic [31:0]   m_dat;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc_n  = 0;
  bit  mon_en = 1'b0;
  bit  stim_on = 1'b0;

  // Reference model state
  bit            mb, mprev;
  int            mo, ml, mw;
  logic [NM-1:0] merr, l_ack, l_err;
  // Masters and slave state
  int            act[NM], beats[NM], gap[NM];
  int            sl_cnt, sl_dly;

  task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act_v, exp_v, cyc_n);
    end
  endtask

  function automatic int pick_dly(input bit wild);
    int r;
    r = int'($urandom_range(0, 15));
    if (!wild || r < 10) return r % 3;
    if (r < 13) return TO - 1;   // ack on the last allowed cycle
    return TO + 12;              // never acks in time
  endfunction

  task automatic new_beat(input int i);
    m_adr[i*32 +: 32] = $urandom;
    m_dat[i*32 +: 32] = $urandom;
    m_sel[i*4 +: 4]   = 4'($urandom);
    m_we[i]           = 1'($urandom);
    m_stb[i]          = 1'b1;
  endtask

  task automatic drop(input int i);
    act[i]   = 0;
    m_cyc[i] = 1'b0;
    m_stb[i] = 1'b0;
    gap[i]   = int'($urandom_range(0, 2));
  endtask

  task automatic model_reset();
    mb = 1'b0; mprev = 1'b0; mo = 0; ml = NM - 1; mw = 0;
    merr = '0; l_ack = '0; l_err = '0;
    sl_cnt = 0; sl_dly = 0;
    for (int i = 0; i < NM; i++) begin
      act[i] = 0; beats[i] = 0; gap[i] = 0;
    end
  endtask

  // One clock cycle of stimulus plus prediction.
  task automatic step();
    ev_t           e;
    logic [NM-1:0] g, nerr;
    bit            gstb, ack, found;
    int            idx, c;
    @(posedge clk);
    #1;
    cyc_n++;
    // masters react to what they saw last cycle
    for (int i = 0; i < NM; i++) begin
      if (act[i] != 0) begin
        if (l_err[i]) begin
          drop(i);
        end else if (m_stb[i] && l_ack[i]) begin
          beats[i]--;
          if (beats[i] == 0) drop(i);
          else if ($urandom_range(0, 3) == 0) m_stb[i] = 1'b0;
          else new_beat(i);
        end else if (!m_stb[i] && $urandom_range(0, 1) == 1) begin
          new_beat(i);
        end
      end else if (gap[i] > 0) begin
        gap[i]--;
      end else if (stim_on && $urandom_range(0, 2) == 0) begin
        act[i]   = 1;
        beats[i] = int'($urandom_range(1, 4));
        m_cyc[i] = 1'b1;
        new_beat(i);
      end
    end
    // slave response
    g = '0;
    if (mb) g[mo] = 1'b1;
    gstb = mb && m_stb[mo];
    if (gstb) ack = (sl_cnt == sl_dly);
    else if (!mb) ack = stim_on && ($urandom_range(0, 7) == 0);
    else ack = 1'b0;
    s_ack   = ack;
    s_dat_i = $urandom;
    // expected outputs of this cycle
    idx     = mb ? mo : 0;
    e.cyc   = cyc_n;
    e.grant = g;
    e.ack   = {NM{ack}} & g;
    e.err   = merr;
    e.s_cyc = mb && m_cyc[mo];
    e.s_stb = gstb;
    e.s_we  = mb && m_we[mo];
    e.s_sel = m_sel[idx*4 +: 4];
    e.s_adr = m_adr[idx*32 +: 32];
    e.s_dat = m_dat[idx*32 +: 32];
    e.m_dat = s_dat_i;
    if (e.ack != '0 || e.err != '0 || (mb && !mprev)) exp_q.push_back(e);
    // state at the next edge
    mprev = mb;
    nerr  = '0;
    if (!mb) begin
      found = 1'b0;
      for (int k = 1; k <= NM; k++) begin
        c = (ml + k) % NM;
        if (!found && m_cyc[c]) begin
          found = 1'b1; mb = 1'b1; mo = c; ml = c;
        end
      end
      mw = 0;
    end else if (!m_cyc[mo]) begin
      mb = 1'b0; mw = 0;
    end else if (gstb && !ack) begin
      if (mw == TO - 1) begin
        nerr[mo] = 1'b1; mb = 1'b0; mw = 0;
      end else begin
        mw++;
      end
    end else begin
      mw = 0;
    end
    l_ack = e.ack;
    l_err = merr;
    merr  = nerr;
    if (gstb && !ack) sl_cnt++;
    else begin
      sl_cnt = 0;
      sl_dly = pick_dly(stim_on);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT shows an event.
  initial begin
    ev_t           ev;
    logic [NM-1:0] prev_g;
    prev_g = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (o_m_ack != '0 || o_m_err != '0 || (o_grant != '0 && prev_g == '0)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", 128'({o_grant, o_m_ack, o_m_err}), 128'(0));
          end else begin
            ev = exp_q.pop_front();
            chk("event_cycle", 128'(cyc_n), 128'(ev.cyc));
            chk("grant_ack_err", 128'({o_grant, o_m_ack, o_m_err}),
                128'({ev.grant, ev.ack, ev.err}));
            chk("slave_port", 128'({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, o_m_dat}),
                128'({ev.s_cyc, ev.s_stb, ev.s_we, ev.s_sel, ev.s_adr, ev.s_dat, ev.m_dat}));
          end
        end
      end
      prev_g = o_grant;
    end
  end

  initial begin
    rst   = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_we  = '0; m_cyc = '0; m_stb = '0;
    s_ack = 1'b1; s_dat_i = 32'h0;
    model_reset();
    // reset state: stray ack must not reach any master
    @(posedge clk);
    #1;
    chk("rst_grant", 128'(o_grant), 128'(0));
    chk("rst_s_cyc_stb", 128'({s_cyc, s_stb, s_we}), 128'(0));
    chk("rst_ack_err", 128'({o_m_ack, o_m_err}), 128'(0));
    s_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_grant", 128'(o_grant), 128'(0));

    // randomized traffic
    model_reset();
    mon_en  = 1'b1;
    stim_on = 1'b1;
    for (int n = 0; n < 3000; n++) step();
    stim_on = 1'b0;
    for (int n = 0; n < 120; n++) step();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    chk("masters_idle", 128'({m_cyc, o_grant}), 128'(0));
    mon_en = 1'b0;

    // asynchronous reset while master 2 owns the bus
    @(posedge clk);
    #1;
    s_ack = 1'b0;
    m_cyc = 3'b100; m_stb = 3'b100;
    m_adr[64 +: 32] = 32'h0000_0040;
    m_dat[64 +: 32] = 32'hCAFE_0002;
    @(posedge clk);
    #1;
    chk("m2_granted", 128'({o_grant, s_stb, s_dat_o}), 128'({3'b100, 1'b1, 32'hCAFE_0002}));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_drop", 128'({s_cyc, s_stb, o_grant, o_m_err}), 128'(0));
    m_cyc = 3'b111; m_stb = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("no_grant_before_edge", 128'(o_grant), 128'(0));
    @(posedge clk);
    #1;
    chk("m0_first_after_rst", 128'({o_grant, s_cyc, s_stb}), 128'({3'b001, 1'b1, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
